axi4lite_master_port: RTL and testbench

AXI4-Lite initiator that converts a simple one-command-at-a-time request interface into AXI4-Lite read and write transactions. It is the driving end for the slave memory subsystem. It also serves as the bus-functional front end for system tests and for any on-chip client that needs register or memory access. It has one outstanding transaction, a registered AXI interface, and returns one response pulse per command.

---
 rtl/axi4lite_master_port.sv | 156 +++++++++++++++
 tb/tb_axi4lite_master_port.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_port.sv
// rtl/axi4lite_master_port.sv - single-outstanding AXI4-Lite initiator driven by a simple command port
module axi4lite_master_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [2:0]                AWPROT,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [2:0]                ARPROT,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  state_t                  state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  // Valids decode only from flops, so they never follow READY combinationally.
  assign cmd_ready = (state_q == S_IDLE);
  assign AWVALID   = (state_q == S_WADDR) && !aw_done_q;
  assign WVALID    = (state_q == S_WADDR) && !w_done_q;
  assign BREADY    = (state_q == S_WRESP);
  assign ARVALID   = (state_q == S_RADDR);
  assign RREADY    = (state_q == S_RDATA);
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign AWPROT    = 3'b000;
  assign ARPROT    = 3'b000;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        // AW and W complete independently; leave once both are done, in any order.
        if (AWVALID && AWREADY) aw_done_d = 1'b1;
        if (WVALID && WREADY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (BVALID) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = BRESP;
        end
      end
      S_RADDR: begin
        if (ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (RVALID) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_master_port.sv
// tb/tb_axi4lite_master_port.sv - randomized bench with a transaction-level model and an AXI slave
module tb_axi4lite_master_port;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [2:0]  AWPROT, ARPROT;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0, BVALID = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] RDATA = '0;

  axi4lite_master_port #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cycle = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] s_mem [64];

  logic        busy, exp_w, last_w;
  int          exp_cycle;
  logic [1:0]  exp_resp, last_resp;
  logic [31:0] exp_rdata, last_rdata;

  logic        cur_write;
  logic [7:0]  cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_strb;
  logic [1:0]  cur_resp, nxt_resp;
  int          cur_da, cur_dw, cur_db, nxt_da, nxt_dw, nxt_db;

  logic        aw_need, w_need, ar_need, have_aw, have_w, b_pending, r_pending;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [7:0]  s_awaddr, s_araddr, p_awaddr, p_araddr;
  logic [31:0] s_wdata, p_wdata;
  logic [3:0]  s_wstrb, p_wstrb;
  logic        p_cmd_ready, p_awv, p_wv, p_arv, p_bready, p_rready;

  logic        acc_seen, rsp_seen;
  int          acc_cycle, rsp_cycle;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", name, got, exp, cycle);
    end
  endtask

  task automatic clear_model();
    busy = 0; exp_cycle = -1; last_w = 0; last_resp = 0; last_rdata = 0;
    aw_need = 0; w_need = 0; ar_need = 0; have_aw = 0; have_w = 0;
    b_pending = 0; r_pending = 0;
    p_cmd_ready = 0; p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
    cmd_valid = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_awvalid", 64'(AWVALID), 64'(0));
    chk("rst_wvalid", 64'(WVALID), 64'(0));
    chk("rst_bready", 64'(BREADY), 64'(0));
    chk("rst_arvalid", 64'(ARVALID), 64'(0));
    chk("rst_rready", 64'(RREADY), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_write", 64'(rsp_write), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_resp", 64'(rsp_resp), 64'(0));
    chk("rst_awaddr", 64'(AWADDR), 64'(0));
    chk("rst_wdata", 64'(WDATA), 64'(0));
    chk("rst_wstrb", 64'(WSTRB), 64'(0));
    chk("rst_araddr", 64'(ARADDR), 64'(0));
  endtask

  // One clock: absorb the events of the previous edge, check outputs, drive the slave.
  task automatic step();
    logic exp_rv;
    @(negedge CLK);
    cycle++;
    if (cmd_valid && p_cmd_ready) begin
      acc_seen = 1; acc_cycle = cycle; rsp_seen = 0;
      cur_write = cmd_write; cur_addr = cmd_addr; cur_wdata = cmd_wdata; cur_strb = cmd_wstrb;
      cur_da = nxt_da; cur_dw = nxt_dw; cur_db = nxt_db; cur_resp = nxt_resp;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      busy = 1; exp_w = cmd_write; exp_resp = nxt_resp;
      if (cmd_write) begin
        aw_need = 1; w_need = 1; exp_rdata = 0;
        for (int i = 0; i < 4; i++)
          if (cmd_wstrb[i]) ref_mem[cmd_addr[7:2]][8*i +: 8] = cmd_wdata[8*i +: 8];
        exp_cycle = cycle + 2 + (cur_da > cur_dw ? cur_da : cur_dw) + cur_db;
      end else begin
        ar_need = 1;
        exp_rdata = ref_mem[cmd_addr[7:2]];
        exp_cycle = cycle + 2 + cur_da + cur_db;
      end
    end
    if (p_awv && AWREADY) begin aw_need = 0; have_aw = 1; s_awaddr = p_awaddr; end
    if (p_wv && WREADY) begin w_need = 0; have_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
    if (p_arv && ARREADY) begin ar_need = 0; r_pending = 1; r_cnt = 0; s_araddr = p_araddr; end
    if (BVALID && p_bready) b_pending = 0;
    if (RVALID && p_rready) r_pending = 0;
    if (have_aw && have_w) begin
      for (int i = 0; i < 4; i++)
        if (s_wstrb[i]) s_mem[s_awaddr[7:2]][8*i +: 8] = s_wdata[8*i +: 8];
      have_aw = 0; have_w = 0; b_pending = 1; b_cnt = 0;
    end

    exp_rv = busy && (cycle == exp_cycle);
    chk("cmd_ready", 64'(cmd_ready), 64'(!busy || exp_rv));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      last_w = exp_w; last_resp = exp_resp; last_rdata = exp_rdata; busy = 0;
    end
    chk("rsp_write", 64'(rsp_write), 64'(last_w));
    chk("rsp_resp", 64'(rsp_resp), 64'(last_resp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(last_rdata));
    chk("awvalid", 64'(AWVALID), 64'(aw_need));
    chk("wvalid", 64'(WVALID), 64'(w_need));
    chk("arvalid", 64'(ARVALID), 64'(ar_need));
    chk("bready", 64'(BREADY), 64'(b_pending));
    chk("rready", 64'(RREADY), 64'(r_pending));
    if (aw_need) chk("awaddr", 64'(AWADDR), 64'(cur_addr));
    if (w_need) begin
      chk("wdata", 64'(WDATA), 64'(cur_wdata));
      chk("wstrb", 64'(WSTRB), 64'(cur_strb));
    end
    if (ar_need) chk("araddr", 64'(ARADDR), 64'(cur_addr));
    chk("prot", 64'({AWPROT, ARPROT}), 64'(0));
    if (rsp_valid) begin rsp_seen = 1; rsp_cycle = cycle; end

    AWREADY = aw_need && (aw_cnt >= cur_da);
    if (aw_need && !AWREADY) aw_cnt++;
    WREADY = w_need && (w_cnt >= cur_dw);
    if (w_need && !WREADY) w_cnt++;
    ARREADY = ar_need && (ar_cnt >= cur_da);
    if (ar_need && !ARREADY) ar_cnt++;
    BVALID = b_pending && (b_cnt >= cur_db);
    if (b_pending && !BVALID) b_cnt++;
    BRESP = BVALID ? cur_resp : 2'($urandom_range(0, 3));
    RVALID = r_pending && (r_cnt >= cur_db);
    if (r_pending && !RVALID) r_cnt++;
    RDATA = RVALID ? s_mem[s_araddr[7:2]] : $urandom;
    RRESP = RVALID ? cur_resp : 2'($urandom_range(0, 3));

    p_cmd_ready = cmd_ready; p_awv = AWVALID; p_wv = WVALID; p_arv = ARVALID;
    p_bready = BREADY; p_rready = RREADY;
    p_awaddr = AWADDR; p_wdata = WDATA; p_wstrb = WSTRB; p_araddr = ARADDR;
  endtask

  task automatic present(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int da, input int dw, input int db,
                         input logic [1:0] resp);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    nxt_da = da; nxt_dw = dw; nxt_db = db; nxt_resp = resp;
    cmd_valid = 1; acc_seen = 0;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 60 && !acc_seen; i++) step();
    if (!acc_seen) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 60 && !rsp_seen; i++) step();
    if (!rsp_seen) chk("rsp_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int da, input int dw, input int db,
                        input logic [1:0] resp);
    present(w, a, d, s, da, dw, db, resp);
    wait_accept();
    cmd_valid = 0;
    wait_rsp();
  endtask

  initial begin
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  resp;
    bit          b2b;
    for (int i = 0; i < 64; i++) begin ref_mem[i] = 0; s_mem[i] = 0; end
    acc_seen = 0; rsp_seen = 0; acc_cycle = 0; rsp_cycle = 0;
    nxt_da = 0; nxt_dw = 0; nxt_db = 0; nxt_resp = 0;
    cur_da = 0; cur_dw = 0; cur_db = 0; cur_resp = 0;
    clear_model();
    #1 chk_reset_outputs();
    step(); step();
    RSTn = 1;
    step();

    present(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00);
    wait_accept();
    cmd_valid = 0;
    chk("t1_awvalid", 64'(AWVALID), 64'(1));
    chk("t1_wvalid", 64'(WVALID), 64'(1));
    chk("t1_awaddr", 64'(AWADDR), 64'h10);
    wait_rsp();
    chk("t1_latency", 64'(rsp_cycle - acc_cycle + 1), 64'(3));
    chk("t1_rsp_write", 64'(rsp_write), 64'(1));
    chk("t1_rsp_resp", 64'(rsp_resp), 64'(0));
    chk("t1_rsp_rdata", 64'(rsp_rdata), 64'(0));

    do_txn(1'b0, 8'h10, 32'h0, 4'h0, 0, 0, 2, 2'b00);
    chk("t2_latency", 64'(rsp_cycle - acc_cycle + 1), 64'(5));
    chk("t2_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("t2_rsp_write", 64'(rsp_write), 64'(0));

    present(1'b1, 8'h20, 32'h12345678, 4'hF, 0, 3, 0, 2'b00);
    wait_accept();
    cmd_valid = 0;
    step();
    chk("t3_aw_dropped", 64'(AWVALID), 64'(0));
    chk("t3_w_held", 64'(WVALID), 64'(1));
    chk("t3_bready_low", 64'(BREADY), 64'(0));
    wait_rsp();
    chk("t3_latency", 64'(rsp_cycle - acc_cycle + 1), 64'(6));

    present(1'b1, 8'h04, 32'hA5A55A5A, 4'hF, 0, 0, 0, 2'b00);
    wait_accept();
    present(1'b0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 2'b00);
    wait_accept();
    chk("t4_b2b_accept", 64'(acc_cycle), 64'(rsp_cycle + 1));
    cmd_valid = 0;
    wait_rsp();
    chk("t4_read_back", 64'(rsp_rdata), 64'hA5A55A5A);

    do_txn(1'b0, 8'h20, 32'h0, 4'h0, 1, 0, 1, 2'b10);
    chk("t5_rsp_resp", 64'(rsp_resp), 64'(2));
    chk("t5_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    step();
    chk("t5_idle", 64'(cmd_ready), 64'(1));

    present(1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 0, 0, 6, 2'b00);
    wait_accept();
    cmd_valid = 0;
    for (int i = 0; i < 20 && !BREADY; i++) step();
    chk("t6_in_wresp", 64'(BREADY), 64'(1));
    #2 RSTn = 0;
    #1 chk_reset_outputs();
    clear_model();
    step(); step();
    RSTn = 1;
    step();
    do_txn(1'b0, 8'h30, 32'h0, 4'h0, 0, 0, 0, 2'b00);
    chk("t6_latency", 64'(rsp_cycle - acc_cycle + 1), 64'(3));
    chk("t6_read_after_reset", 64'(rsp_rdata), 64'hCAFEF00D);

    for (int n = 0; n < 200; n++) begin
      w    = 1'($urandom_range(0, 1));
      a    = 8'($urandom_range(0, 15) << 2);
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      resp = 2'($urandom_range(0, 3));
      b2b  = ($urandom_range(0, 3) == 0) && (n < 199);
      present(w, a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), resp);
      wait_accept();
      if (!b2b) begin
        cmd_valid = 0;
        wait_rsp();
        repeat ($urandom_range(0, 2)) step();
      end
    end
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
